// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer for the pipelined LC-3b.
// Issues single accesses and two-access LDI/STI, applies byte lane rules and holds the
// pipe until the read result is latched for MEM/WB.
module mem_access_ctrl #(
  parameter bit BYTE_SEXT = 1'b1  // 1: LDB sign-extends the selected byte, 0: zero-extends
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        ctrl_mem_read,
  input  logic        ctrl_mem_write,
  input  logic        ctrl_indirect,
  input  logic        ctrl_byte,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        pipe_advance,
  output logic        stall,
  output logic [15:0] load_data,
  output logic        done,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {StIdle, StPtr, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] load_q, load_d;
  // Control bits captured at issue so a flush of the EX/MEM control word cannot
  // change an access that is already in flight.
  logic        write_q, write_d;
  logic        indir_q, indir_d;
  logic        byte_q, byte_d;

  logic        mem_op;
  logic [15:0] eff_addr;
  logic [7:0]  rd_byte;
  logic [15:0] rd_byte_ext;

  assign mem_op      = op_valid & (ctrl_mem_read | ctrl_mem_write);
  assign eff_addr    = indir_q ? ptr_q : addr_i;
  assign rd_byte     = eff_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
  assign rd_byte_ext = {{8{BYTE_SEXT & rd_byte[7]}}, rd_byte};
  assign load_data   = load_q;

  // State, pointer, result and captured control bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      load_q  <= '0;
      write_q <= 1'b0;
      indir_q <= 1'b0;
      byte_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      load_q  <= load_d;
      write_q <= write_d;
      indir_q <= indir_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state logic and memory port decode from the registered state.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    load_d          = load_q;
    write_d         = write_q;
    indir_d         = indir_q;
    byte_d          = byte_q;
    stall           = 1'b0;
    done            = 1'b0;
    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_wdata       = '0;
    mem_byte_enable = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          stall   = 1'b1;
          write_d = ctrl_mem_write;
          indir_d = ctrl_indirect;
          byte_d  = ctrl_byte;
          state_d = ctrl_indirect ? StPtr : StAccess;
        end
      end
      StPtr: begin
        stall       = 1'b1;
        mem_read    = 1'b1;
        mem_address = {addr_i[15:1], 1'b0};
        if (mem_resp) begin
          ptr_d   = mem_rdata;
          state_d = StAccess;
        end
      end
      StAccess: begin
        stall       = 1'b1;
        mem_address = byte_q ? eff_addr : {eff_addr[15:1], 1'b0};
        if (write_q) begin
          mem_write = 1'b1;
          if (byte_q) begin
            mem_wdata       = {wdata_i[7:0], wdata_i[7:0]};
            mem_byte_enable = eff_addr[0] ? 2'b10 : 2'b01;
          end else begin
            mem_wdata       = wdata_i;
            mem_byte_enable = 2'b11;
          end
        end else begin
          mem_read = 1'b1;
        end
        if (mem_resp) begin
          done    = 1'b1;
          state_d = StDone;
          if (!write_q) begin
            load_d = byte_q ? rd_byte_ext : mem_rdata;
          end
        end
      end
      StDone: begin
        // Wait for MEM/WB to take the result; a held pipe must not reissue the access.
        if (pipe_advance) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
